// File: rtl/img_pkg.sv
// Shared definitions for the image link (receive loader and transmit path).
// Contents: loader state encoding, frame geometry defaults and a helper
// that maps a capture state to the byte lane it fills.
// Optional build macro GRAY_EXPAND_EN (used by the loader and packer).
package img_pkg;

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned PIXEL_COUNT_DEF = 6767;
  localparam int unsigned ADDR_BITS_DEF   = 13;
  localparam int unsigned RAM_WIDTH_DEF   = 24;

  // Lane 0 = R (bits 23:16), lane 1 = G (15:8), lane 2 = B (7:0).
  function automatic logic [1:0] lane_of(state_t s);
    case (s)
      S_B1:    lane_of = 2'd1;
      S_B2:    lane_of = 2'd2;
      default: lane_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rgb_packer.sv
// Byte-lane select plus 24-bit pixel assembly register.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset, clears the word
//   lane  - target lane (0=R, 1=G, 2=B)
//   data  - incoming byte
//   load  - write data into the selected lane this cycle
//   word  - assembled {R,G,B} pixel
// Build macro GRAY_EXPAND_EN: a lane-0 load replicates the byte to all lanes.
module rgb_packer
  import img_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               lane,
  input  logic [7:0]               data,
  input  logic                     load,
  output logic [RAM_WIDTH_DEF-1:0] word
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
    end else if (load) begin
`ifdef GRAY_EXPAND_EN
      if (lane == 2'd0) begin
        word <= {3{data}};
      end
`else
      case (lane)
        2'd0:    word[23:16] <= data;
        2'd1:    word[15:8]  <= data;
        default: word[7:0]   <= data;
      endcase
`endif
    end
  end

endmodule

// File: rtl/uart_img_loader.sv
// Receive side of the image link: pops bytes from the UART rx FIFO, packs
// them into 24-bit pixels and writes them to the image RAM at addresses
// 0..PIXEL_COUNT-1, then raises done until start or reset.
// Ports:
//   clk, reset (async active-low), start (restart pulse)
//   rx_empty, r_data  - UART FIFO status / head byte
//   rd_uart           - FIFO pop strobe
//   we, addr, wdata   - RAM write port
//   busy, done        - frame status
// Build macro GRAY_EXPAND_EN: one byte per pixel, replicated to R, G and B.
module uart_img_loader
  import img_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = ADDR_BITS_DEF,
  parameter int unsigned PIXEL_COUNT = PIXEL_COUNT_DEF,
  parameter int unsigned RAM_WIDTH   = RAM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rx_empty,
  input  logic [7:0]           r_data,
  output logic                 rd_uart,
  output logic                 we,
  output logic [ADDR_BITS-1:0] addr,
  output logic [RAM_WIDTH-1:0] wdata,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(PIXEL_COUNT - 1);

  state_t state;
  logic   capture;

  assign capture = (state == S_B0) || (state == S_B1) || (state == S_B2);

  // Pop and write are decoded combinationally so that start can veto them in
  // the same cycle; reset gates the pop because the reset state is a capture
  // state and the FIFO may be non-empty while reset is held.
  assign rd_uart = reset & ~start & capture & ~rx_empty;
  assign we      = reset & ~start & (state == S_WR);
  assign busy    = (state != S_DONE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_B0;
      addr  <= '0;
    end else if (start) begin
      state <= S_B0;
      addr  <= '0;
    end else begin
      unique case (state)
        S_B0: begin
          if (!rx_empty) begin
`ifdef GRAY_EXPAND_EN
            state <= S_WR;
`else
            state <= S_B1;
`endif
          end
        end
        S_B1: if (!rx_empty) state <= S_B2;
        S_B2: if (!rx_empty) state <= S_WR;
        S_WR: begin
          if (addr == LastAddr) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_B0;
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_B0;
      endcase
    end
  end

  rgb_packer u_packer (
    .clk   (clk),
    .reset (reset),
    .lane  (lane_of(state)),
    .data  (r_data),
    .load  (rd_uart),
    .word  (wdata)
  );

endmodule

// File: tb/tb_uart_img_loader.sv
// Directed self-checking bench for uart_img_loader. A byte queue stands in
// for the UART rx FIFO; each step drives inputs at the falling edge and
// samples outputs 1 ns later.
module tb_uart_img_loader;

`ifdef GRAY_EXPAND_EN
  localparam int BPP = 1;
`else
  localparam int BPP = 3;
`endif
  localparam int NPIX = 6767;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        we;
  logic [12:0] addr;
  logic [23:0] wdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_img_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done)
  );

  logic [7:0] fifo[$];
  int         passed = 0;
  int         failed = 0;
  int         total  = 0;
  int         pops = 0, writes = 0, cyc = 0;
  int         last_pop_cyc = 0, w_cyc = 0;
  logic [12:0] w_addr;
  logic [23:0] w_data;
  logic        overlap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st);
    @(negedge clk);
    start    = st;
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
    #1;
    cyc++;
    if (rd_uart === 1'b1) begin
      void'(fifo.pop_front());
      pops++;
      last_pop_cyc = cyc;
    end
    if (we === 1'b1) begin
      writes++;
      w_addr = addr;
      w_data = wdata;
      w_cyc  = cyc;
    end
    if (we === 1'b1 && rd_uart === 1'b1) overlap = 1'b1;
  endtask

  task automatic pop_n(input string tag, input int n);
    int target;
    target = pops + n;
    for (int i = 0; i < 60 && pops < target; i++) step(1'b0);
    chk(tag, pops, target);
  endtask

  task automatic wait_write(input string tag);
    int target;
    target = writes + 1;
    for (int i = 0; i < 60 && writes < target; i++) step(1'b0);
    chk(tag, writes, target);
  endtask

  function automatic logic [7:0] pat(input int j);
    return 8'((j * 7 + 1) % 256);
  endfunction

  function automatic logic [23:0] exp_pix(input int n);
`ifdef GRAY_EXPAND_EN
    return {3{pat(n)}};
`else
    return {pat(3 * n), pat(3 * n + 1), pat(3 * n + 2)};
`endif
  endfunction

  initial begin
    int p0, w0, fw, bad, budget;

    // Reset state, with a byte presented to prove the pop is gated.
    reset = 1'b0; start = 1'b0; rx_empty = 1'b0; r_data = 8'h5A;
    #12;
    chk("rst_rd_uart", rd_uart, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1; rx_empty = 1'b1;

`ifdef GRAY_EXPAND_EN
    fifo.push_back(8'h80);
    step(1'b0);
    chk("gray_pop", pops, 1);
    wait_write("gray_wr0");
    chk("gray_latency", w_cyc, last_pop_cyc + 1);
    chk("gray_addr0", w_addr, 0);
    chk("gray_data0", w_data, 24'h808080);
    chk("gray_pops_total", pops, 1);
    fifo.push_back(8'h3C);
    wait_write("gray_wr1");
    chk("gray_addr1", w_addr, 1);
    chk("gray_data1", w_data, 24'h3C3C3C);
`else
    // Back-to-back R,G,B.
    fifo.push_back(8'h11); fifo.push_back(8'h22); fifo.push_back(8'h33);
    wait_write("p0_wr");
    chk("p0_pops", pops, 3);
    chk("p0_latency", w_cyc, last_pop_cyc + 1);
    chk("p0_addr", w_addr, 0);
    chk("p0_data", w_data, 24'h112233);
    step(1'b0);
    chk("p0_addr_next", addr, 1);

    // Five empty cycles between G and B.
    fifo.push_back(8'h44); fifo.push_back(8'h55);
    pop_n("p1_rg", 2);
    p0 = pops; w0 = writes;
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("p1_gap_no_pop", pops, p0);
    chk("p1_gap_no_write", writes, w0);
    fifo.push_back(8'h66);
    wait_write("p1_wr");
    chk("p1_addr", w_addr, 1);
    chk("p1_data", w_data, 24'h445566);

    // Pixels 2 and 3, then start after two bytes of pixel 4.
    for (int i = 0; i < 6; i++) fifo.push_back(8'(8'hA0 + i));
    wait_write("p2_wr");
    wait_write("p3_wr");
    chk("p3_addr", w_addr, 3);
    chk("p3_data", w_data, 24'hA3A4A5);
    fifo.push_back(8'h01); fifo.push_back(8'h02);
    pop_n("p4_partial", 2);
    w0 = writes;
    step(1'b1);
    step(1'b0);
    chk("p4_no_write", writes, w0);
    chk("p4_addr_restart", addr, 0);
    fifo.push_back(8'hAA); fifo.push_back(8'hBB); fifo.push_back(8'hCC);
    wait_write("rs_wr");
    chk("rs_addr", w_addr, 0);
    chk("rs_data", w_data, 24'hAABBCC);

    // start during the write cycle suppresses the write.
    fifo.push_back(8'h07); fifo.push_back(8'h08); fifo.push_back(8'h09);
    pop_n("swr_bytes", 3);
    w0 = writes;
    step(1'b1);
    chk("swr_we_suppressed", writes, w0);
    step(1'b0);
    chk("swr_addr", addr, 0);
`endif

    // Full frame from address 0.
    fifo.delete();
    step(1'b1);
    for (int j = 0; j < NPIX * BPP; j++) fifo.push_back(pat(j));
    fw = 0; bad = 0;
    budget = NPIX * (BPP + 1) + 100;
    for (int i = 0; i < budget && done !== 1'b1; i++) begin
      w0 = writes;
      step(1'b0);
      if (writes != w0) begin
        if (w_addr !== 13'(fw) || w_data !== exp_pix(fw)) bad++;
        fw++;
      end
    end
    chk("frame_writes", fw, NPIX);
    chk("frame_bad_pixels", bad, 0);
    chk("frame_last_addr", w_addr, NPIX - 1);
    chk("frame_done", done, 1);
    chk("frame_busy", busy, 0);
    fifo.push_back(8'hEE);
    p0 = pops;
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("done_no_pop", pops, p0);
    chk("done_fifo_kept", fifo.size(), 1);
    chk("done_held", done, 1);
    chk("done_addr_held", addr, NPIX - 1);

    // start leaves S_DONE.
    fifo.delete();
    step(1'b1);
    step(1'b0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_addr", addr, 0);

    // Reset asserted in the middle of the write of pixel 1.
    for (int i = 0; i < 2 * BPP; i++) fifo.push_back(8'(8'h10 + i));
    wait_write("rw_first");
    pop_n("rw_bytes", BPP);
    step(1'b0);
    chk("rw_we_before", we, 1);
    chk("rw_addr_before", addr, 1);
    #1 reset = 1'b0;
    #1;
    chk("rw_we_async", we, 0);
    chk("rw_rd_async", rd_uart, 0);
    chk("rw_addr_async", addr, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < BPP; i++) fifo.push_back(8'(8'h70 + i));
    wait_write("rw_after");
    chk("rw_after_addr", w_addr, 0);
`ifdef GRAY_EXPAND_EN
    chk("rw_after_data", w_data, 24'h707070);
`else
    chk("rw_after_data", w_data, 24'h707172);
`endif

    chk("no_we_rd_overlap", overlap, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
